// File: rtl/box_reporter.sv
// rtl/box_reporter.sv - snapshots the bounding-box bank at end of frame and streams it as a byte packet
//
// Ports:
//   app_clk, app_rst_n   clock and synchronous active-low reset
//   frame_done           end-of-frame strobe; box set is final on this cycle
//   boxes_in             MAX_OBJ_NUM slots of {right, left, bottom, top}, top at the LSB
//   valid_in             per-slot live flags
//   tx_data/tx_valid     packet byte stream toward the link transmitter
//   tx_ready             sink accepts the current byte
//   busy                 a packet is in flight
//   frames_dropped       saturating count of frame_done strobes ignored while busy
//
// Packet: A5, seq, N, {top, bottom, left, right} x N as 16-bit big-endian, checksum.
// The checksum is the mod-256 sum of every byte after the A5 sync byte.

module box_reporter #(
    parameter int MAX_OBJ_NUM = 15,
    parameter int COORD_BITS  = 11
) (
    input  logic                                app_clk,
    input  logic                                app_rst_n,
    input  logic                                frame_done,
    input  logic [MAX_OBJ_NUM*4*COORD_BITS-1:0] boxes_in,
    input  logic [MAX_OBJ_NUM-1:0]              valid_in,
    output logic [7:0]                          tx_data,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    output logic                                busy,
    output logic [7:0]                          frames_dropped
);

    localparam int BOX_W = 4 * COORD_BITS;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SYNC  = 3'd1;
    localparam logic [2:0] ST_SEQ   = 3'd2;
    localparam logic [2:0] ST_CNT   = 3'd3;
    localparam logic [2:0] ST_SCAN  = 3'd4;
    localparam logic [2:0] ST_BOX   = 3'd5;
    localparam logic [2:0] ST_CKSUM = 3'd6;

    logic [2:0]                          state;
    logic [MAX_OBJ_NUM*BOX_W-1:0]        snap_boxes;
    logic [MAX_OBJ_NUM-1:0]              snap_valid;
    logic [7:0]                          snap_cnt;
    logic [7:0]                          frame_seq;
    logic [7:0]                          cksum;
    logic [7:0]                          scan_idx;
    logic [2:0]                          byte_idx;

    logic                                xfer;
    logic [7:0]                          pop_cnt;
    logic [BOX_W-1:0]                    cur_box;
    logic                                cur_valid;
    logic [2:0]                          sel_byte;
    logic [COORD_BITS-1:0]               coord;
    logic [15:0]                         coord16;
    logic [7:0]                          box_byte;

    assign xfer = tx_valid && tx_ready;

    always_comb begin
        pop_cnt = 8'd0;
        for (int i = 0; i < MAX_OBJ_NUM; i++) begin
            pop_cnt = pop_cnt + 8'(valid_in[i]);
        end
    end

    // Slot mux driven by scan_idx; indices past the last slot read as empty,
    // which is what lets SCAN fall through to the checksum.
    always_comb begin
        cur_box   = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < MAX_OBJ_NUM; i++) begin
            if (scan_idx == 8'(i)) begin
                cur_box   = snap_boxes[i*BOX_W +: BOX_W];
                cur_valid = snap_valid[i];
            end
        end
    end

    // Byte to load next: byte 0 when entering BOX from SCAN, otherwise the
    // one after the byte currently on the bus. Even bytes are the high half.
    always_comb begin
        sel_byte = (state == ST_BOX) ? byte_idx + 3'd1 : 3'd0;
        case (sel_byte[2:1])
            2'd0:    coord = cur_box[0*COORD_BITS +: COORD_BITS];
            2'd1:    coord = cur_box[1*COORD_BITS +: COORD_BITS];
            2'd2:    coord = cur_box[2*COORD_BITS +: COORD_BITS];
            default: coord = cur_box[3*COORD_BITS +: COORD_BITS];
        endcase
        coord16  = 16'(coord);
        box_byte = sel_byte[0] ? coord16[7:0] : coord16[15:8];
    end

    always_ff @(posedge app_clk) begin
        if (!app_rst_n) begin
            state          <= ST_IDLE;
            snap_boxes     <= '0;
            snap_valid     <= '0;
            snap_cnt       <= 8'd0;
            frame_seq      <= 8'd0;
            cksum          <= 8'd0;
            scan_idx       <= 8'd0;
            byte_idx       <= 3'd0;
            tx_data        <= 8'd0;
            tx_valid       <= 1'b0;
            busy           <= 1'b0;
            frames_dropped <= 8'd0;
        end else begin
            if (frame_done && state != ST_IDLE && frames_dropped != 8'hFF) begin
                frames_dropped <= frames_dropped + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_done) begin
                        snap_boxes <= boxes_in;
                        snap_valid <= valid_in;
                        snap_cnt   <= pop_cnt;
                        tx_data    <= 8'hA5;
                        tx_valid   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (xfer) begin
                        tx_data <= frame_seq;
                        cksum   <= 8'd0;
                        state   <= ST_SEQ;
                    end
                end
                ST_SEQ: begin
                    if (xfer) begin
                        cksum   <= cksum + tx_data;
                        tx_data <= snap_cnt;
                        state   <= ST_CNT;
                    end
                end
                ST_CNT: begin
                    if (xfer) begin
                        cksum    <= cksum + tx_data;
                        tx_valid <= 1'b0;
                        scan_idx <= 8'd0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_idx >= 8'(MAX_OBJ_NUM)) begin
                        tx_data  <= cksum;
                        tx_valid <= 1'b1;
                        state    <= ST_CKSUM;
                    end else if (cur_valid) begin
                        byte_idx <= 3'd0;
                        tx_data  <= box_byte;
                        tx_valid <= 1'b1;
                        state    <= ST_BOX;
                    end else begin
                        scan_idx <= scan_idx + 8'd1;
                    end
                end
                ST_BOX: begin
                    if (xfer) begin
                        cksum <= cksum + tx_data;
                        if (byte_idx == 3'd7) begin
                            tx_valid <= 1'b0;
                            scan_idx <= scan_idx + 8'd1;
                            state    <= ST_SCAN;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= box_byte;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (xfer) begin
                        tx_valid  <= 1'b0;
                        busy      <= 1'b0;
                        frame_seq <= frame_seq + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/box_reporter.md
# box_reporter

Reads the bounding-box list produced by the blob segmentation stage at each end of frame and serialises it into a byte-stream packet for the node's host link (UART/Ethernet TX byte interface). It sits downstream of the box register bank and upstream of the link transmitter. It snapshots the whole box set in one cycle, so the segmenter can start on the next frame while the packet drains.

## Interface

Parameters:
- MAX_OBJ_NUM, 15, number of box slots; must be ≤ 255.
- COORD_BITS, 11, width of one coordinate; must be ≤ 16.

Ports:
- app_clk  in  1  single clock, same as the video/app clock.
- app_rst_n  in  1  reset: synchronous, active-low.
- frame_done  in  1  one-cycle strobe; box set is final on this cycle.
- boxes_in  in  MAX_OBJ_NUM*4*COORD_BITS  slot i at offset 4*COORD_BITS*i, with fields from LSB: top, bottom, left, right.
- valid_in  in  MAX_OBJ_NUM  bit i set means slot i holds a live box.
- tx_data  out  8  packet byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte.
- busy  out  1  a packet is in flight.
- frames_dropped  out  8  saturating count of frame_done strobes that were ignored.

## Operation

- **Snapshot.** frame_done with state IDLE latches boxes_in, valid_in, and count N = popcount(valid_in). The frame is accepted.
- **Drop.** frame_done in any other state is ignored. frames_dropped increments and saturates at 255. frame_seq does not change.
- **Packet layout**, in order:
  - 0xA5
  - frame_seq[7:0]
  - N
  - for each set snapshot bit, ascending index: top, bottom, left, right, each as 2 bytes big-endian, zero-extended to 16 bits
  - checksum
- **Checksum** = sum mod 256 of every byte from frame_seq through the last coordinate byte. 0xA5 is excluded.
- **frame_seq** starts at 0 and increments (wraps 255→0) when the checksum byte transfers.
- **FSM**:
  - IDLE: on accepted frame_done → SYNC.
  - SYNC, then SEQ, then CNT: each advances on transfer.
  - CNT → SCAN.
  - SCAN: examines one slot index per cycle, starting at 0 for each packet, with tx_valid low.
    - Set bit found → BOX with byte index 0.
    - Index passes MAX_OBJ_NUM-1 → CKSUM.
  - BOX: 8 bytes, byte index 0..7; advances on transfer. After byte 7 → SCAN at the next index.
  - CKSUM: on transfer → IDLE.
- **N = 0** gives a 4-byte packet: A5, seq, 00, checksum. The checksum equals seq.

## Timing

- **Transfer** happens on a cycle where tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable.
  - tx_valid never depends combinationally on tx_ready.
  - All outputs are registered.
- **Latency.** Accepted frame_done at cycle 0 gives tx_valid=1 with tx_data=0xA5 at cycle 1.
- **busy**:
  - Rises in cycle 1.
  - Falls in the cycle after the checksum transfer.
- **frame_done in the same cycle as the checksum transfer** is dropped, because the state is not IDLE.
- **Back-to-back frames.** The next frame_done is accepted no earlier than the cycle after busy falls.
- **SCAN cost** is one cycle per slot examined. With a 15-slot bank, a full packet completes well within one video frame at full tx_ready.
- **Reset values**, set when app_rst_n=0 at a clock edge:
  - tx_valid=0, tx_data=0, busy=0, frames_dropped=0.
  - frame_seq=0, state IDLE.
  - Reset mid-packet aborts it: tx_valid is low after that edge, and the partial packet is discarded.

## Test plan

- **Single box.** After reset, valid_in=0x0001, slot 0 = {top 10, bottom 100, left 20, right 300}, pulse frame_done, tx_ready=1 constant. Stream is A5 00 01 00 0A 00 64 00 14 01 2C B0; busy then falls.
- **Empty frame.** Two frame_done pulses with valid_in=0. Packets are A5 00 00 00 then A5 01 00 01.
- **Sparse mask.** valid_in=0x4011 with distinct coordinates in slots 0, 4 and 14. N=03, then 24 coordinate bytes in slot order 0, 4, 14, then the checksum matching the reference model.
- **Backpressure.** Single-box case with tx_ready random at 30% duty. Byte sequence is identical to the single-box case, and tx_data is never changed while tx_valid && !tx_ready.
- **Drop.** frame_done pulsed 3 times during a packet, plus once in the checksum-transfer cycle, and boxes_in changed mid-packet. frames_dropped=4, the packet content is unchanged, and the next accepted packet carries seq+1.
- **Reset mid-packet.** app_rst_n low for 1 cycle after byte 5, then a new frame. tx_valid=0 after the reset edge, frames_dropped=0, and the new packet starts A5 00.
